// File: rtl/dt_pkg.sv
// Shared DT definitions: image geometry, pixel encodings, loader state and border test.
package dt_pkg;

   localparam int IMG_W     = 128;
   localparam int IMG_H     = 128;
   localparam int STI_WORDS = 1024;
   localparam int PIX_BITS  = 8;

   localparam logic [PIX_BITS-1:0] PIX_BG  = 8'h00;
   localparam logic [PIX_BITS-1:0] PIX_OBJ = 8'h01;

   typedef enum logic [1:0] {IDLE, FETCH, UNPACK, DONE} ld_state_t;

   // addr = row*128 + col; true for the outermost ring of the image
   function automatic logic is_border(input logic [13:0] addr);
      return (addr[13:7] == 7'd0) || (addr[13:7] == 7'(IMG_H - 1)) ||
             (addr[6:0]  == 7'd0) || (addr[6:0]  == 7'(IMG_W - 1));
   endfunction

endpackage

// File: rtl/dt_sti_loader.sv
// Expands the packed 1-bit sti_ROM image into one byte per pixel in res_RAM.
module dt_sti_loader
   import dt_pkg::*;
#(
   parameter bit CLEAR_BORDER = 1'b0,
   parameter bit WRITE_ZEROS  = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        busy,
   output logic        load_done,
   output logic [14:0] fg_count,
   output logic        sti_rd,
   output logic [9:0]  sti_addr,
   input  logic [15:0] sti_di,
   output logic        res_wr,
   output logic [13:0] res_addr,
   output logic [7:0]  res_do
);

   localparam logic [9:0] LAST_WORD = 10'(STI_WORDS - 1);

   ld_state_t   state;
   logic [9:0]  word;
   logic [3:0]  k;
   logic [15:0] shreg;

   logic [9:0]  nxt_word;
   logic [3:0]  nxt_k;
   logic        nxt_src;
   logic        nxt_bit;

   // Outputs are registered, so each edge prepares the pixel shown in the following cycle;
   // on a word boundary that pixel comes straight from sti_di rather than the shift register.
   always_comb begin
      nxt_word = word;
      nxt_k    = k + 4'd1;
      nxt_src  = shreg[14];
      if (state == FETCH) begin
         nxt_k   = '0;
         nxt_src = sti_di[15];
      end else if (k == 4'd15) begin
         nxt_word = word + 10'd1;
         nxt_src  = sti_di[15];
      end
      nxt_bit = nxt_src && !(CLEAR_BORDER && is_border({nxt_word, nxt_k}));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         load_done <= 1'b0;
         fg_count  <= '0;
         sti_rd    <= 1'b0;
         sti_addr  <= '0;
         res_wr    <= 1'b0;
         res_addr  <= '0;
         res_do    <= '0;
         word      <= '0;
         k         <= '0;
         shreg     <= '0;
      end else begin
         sti_rd    <= 1'b0;
         res_wr    <= 1'b0;
         load_done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= FETCH;
                  busy     <= 1'b1;
                  fg_count <= '0;
                  word     <= '0;
                  k        <= '0;
                  sti_rd   <= 1'b1;
                  sti_addr <= '0;
               end
            end
            FETCH, UNPACK: begin
               if (state == UNPACK && k == 4'd15 && word == LAST_WORD) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  load_done <= 1'b1;
               end else begin
                  state    <= UNPACK;
                  shreg    <= (state == FETCH || k == 4'd15) ? sti_di : {shreg[14:0], 1'b0};
                  word     <= nxt_word;
                  k        <= nxt_k;
                  res_wr   <= WRITE_ZEROS ? 1'b1 : nxt_bit;
                  res_addr <= {nxt_word, nxt_k};
                  res_do   <= nxt_bit ? PIX_OBJ : PIX_BG;
                  fg_count <= fg_count + {14'd0, nxt_bit};
                  // Prefetch so the k=15 cycle carries the next word's read
                  if (state == UNPACK && k == 4'd14 && word != LAST_WORD) begin
                     sti_rd   <= 1'b1;
                     sti_addr <= word + 10'd1;
                  end
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dt_sti_loader.sv
// Directed bench: three loader instances (default, CLEAR_BORDER=1, WRITE_ZEROS=0) on a shared ROM image.
module tb_dt_sti_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        busy      [3];
   logic        load_done [3];
   logic [14:0] fg_count  [3];
   logic        sti_rd    [3];
   logic [9:0]  sti_addr  [3];
   logic [15:0] sti_di    [3];
   logic        res_wr    [3];
   logic [13:0] res_addr  [3];
   logic [7:0]  res_do    [3];

   logic [15:0] rom [1024];
   logic [7:0]  ram [3][16384];
   logic        ram_fill = 1'b0;

   int tests = 0;
   int fails = 0;

   int          done_n [3];
   int          wr_cnt [3];
   int          ld_cnt [3];
   int          wr_first, wr_last;
   logic [9:0]  addr_at95;
   logic        rd_at95;
   logic [13:0] wz_addr [4];

   always #5 clk = ~clk;

   dt_sti_loader u_dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy[0]), .load_done(load_done[0]),
      .fg_count(fg_count[0]), .sti_rd(sti_rd[0]), .sti_addr(sti_addr[0]), .sti_di(sti_di[0]),
      .res_wr(res_wr[0]), .res_addr(res_addr[0]), .res_do(res_do[0]));

   dt_sti_loader #(.CLEAR_BORDER(1'b1)) u_cb (
      .clk(clk), .reset(reset), .start(start), .busy(busy[1]), .load_done(load_done[1]),
      .fg_count(fg_count[1]), .sti_rd(sti_rd[1]), .sti_addr(sti_addr[1]), .sti_di(sti_di[1]),
      .res_wr(res_wr[1]), .res_addr(res_addr[1]), .res_do(res_do[1]));

   dt_sti_loader #(.WRITE_ZEROS(1'b0)) u_wz (
      .clk(clk), .reset(reset), .start(start), .busy(busy[2]), .load_done(load_done[2]),
      .fg_count(fg_count[2]), .sti_rd(sti_rd[2]), .sti_addr(sti_addr[2]), .sti_di(sti_di[2]),
      .res_wr(res_wr[2]), .res_addr(res_addr[2]), .res_do(res_do[2]));

   always @(negedge clk)
      for (int i = 0; i < 3; i++)
         if (sti_rd[i]) sti_di[i] <= rom[sti_addr[i]];

   always @(posedge clk) begin
      if (ram_fill) begin
         for (int i = 0; i < 3; i++)
            for (int a = 0; a < 16384; a++)
               ram[i][a] <= (i == 2) ? 8'h00 : 8'hAA;
      end else begin
         for (int i = 0; i < 3; i++)
            if (res_wr[i]) ram[i][res_addr[i]] <= res_do[i];
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   function automatic logic [7:0] exp_pix(input int inst, input int a);
      logic [15:0] wd;
      int r, c;
      wd = rom[a / 16];
      r  = a / 128;
      c  = a % 128;
      if (inst == 1 && (r == 0 || r == 127 || c == 0 || c == 127)) return 8'h00;
      return {7'd0, wd[15 - (a % 16)]};
   endfunction

   function automatic int count_bad(input int inst);
      int bad = 0;
      for (int a = 0; a < 16384; a++)
         if (ram[inst][a] !== exp_pix(inst, a)) bad++;
      return bad;
   endfunction

   function automatic int exp_fg(input int inst);
      int n = 0;
      for (int a = 0; a < 16384; a++)
         if (exp_pix(inst, a) == 8'h01) n++;
      return n;
   endfunction

   task automatic fill_ram();
      @(negedge clk) ram_fill = 1'b1;
      @(negedge clk) ram_fill = 1'b0;
   endtask

   // n counts posedges after the start-sampling edge P; value seen after edge P+n is cycle P+n+1
   task automatic run_load(input int abort_at, input bit repulse);
      for (int i = 0; i < 3; i++) begin
         done_n[i] = 0; wr_cnt[i] = 0; ld_cnt[i] = 0;
      end
      wr_first = -1; wr_last = -1; addr_at95 = 'x; rd_at95 = 1'bx;
      @(negedge clk) start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int n = 1; n <= 17000; n++) begin
         @(posedge clk); #1;
         start = 1'b0;
         for (int i = 0; i < 3; i++) begin
            if (res_wr[i]) begin
               if (i == 2 && wr_cnt[2] < 4) wz_addr[wr_cnt[2]] = res_addr[2];
               wr_cnt[i]++;
            end
            if (load_done[i]) begin
               ld_cnt[i]++;
               done_n[i] = n;
            end
         end
         if (res_wr[0]) begin
            if (wr_first < 0) wr_first = n;
            wr_last = n;
            if (res_addr[0] == 14'd95) begin
               addr_at95 = sti_addr[0];
               rd_at95   = sti_rd[0];
            end
         end
         if (repulse && (n == 500 || load_done[0])) start = 1'b1;
         if (n == abort_at) begin
            reset = 1'b1;
            @(posedge clk); #1 reset = 1'b0;
            check_eq("abort_busy",   busy[0],     0);
            check_eq("abort_fg",     fg_count[0], 0);
            check_eq("abort_res_wr", res_wr[0],   0);
            check_eq("abort_sti_rd", sti_rd[0],   0);
            repeat (3) @(posedge clk);
            #1 check_eq("abort_idle_busy", busy[0], 0);
            return;
         end
         if (done_n[0] > 0 && n >= done_n[0] + 4) break;
      end
      check_eq("load_done_seen", done_n[0] != 0, 1);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      for (int w = 0; w < 1024; w++) rom[w] = 16'h0000;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_busy",      busy[0],      0);
      check_eq("rst_load_done", load_done[0], 0);
      check_eq("rst_sti_rd",    sti_rd[0],    0);
      check_eq("rst_res_wr",    res_wr[0],    0);
      check_eq("rst_sti_addr",  sti_addr[0],  0);
      check_eq("rst_res_addr",  res_addr[0],  0);
      check_eq("rst_res_do",    res_do[0],    0);
      check_eq("rst_fg",        fg_count[0],  0);
      @(negedge clk) reset = 1'b0;

      // All-zero image, with extra starts at n=500 and in the load_done cycle
      fill_ram();
      run_load(0, 1'b1);
      check_eq("z_done_cycle", done_n[0], 16385);
      check_eq("z_wr_count",   wr_cnt[0], 16384);
      check_eq("z_wr_first",   wr_first,  1);
      check_eq("z_wr_last",    wr_last,   16384);
      check_eq("z_ld_pulses",  ld_cnt[0], 1);
      check_eq("z_fg",         fg_count[0], 0);
      check_eq("z_image",      count_bad(0), 0);
      check_eq("z_wz_writes",  wr_cnt[2], 0);
      check_eq("z_wz_done",    done_n[2], 16385);
      check_eq("z_busy_after", busy[0], 0);

      // All-ones image
      for (int w = 0; w < 1024; w++) rom[w] = 16'hFFFF;
      fill_ram();
      run_load(0, 1'b0);
      check_eq("o_fg",       fg_count[0], 16384);
      check_eq("o_image",    count_bad(0), 0);
      check_eq("o_cb_fg",    fg_count[1], 15876);
      check_eq("o_cb_fg_m",  fg_count[1], exp_fg(1));
      check_eq("o_cb_0",     ram[1][0],     8'h00);
      check_eq("o_cb_127",   ram[1][127],   8'h00);
      check_eq("o_cb_128",   ram[1][128],   8'h00);
      check_eq("o_cb_16383", ram[1][16383], 8'h00);
      check_eq("o_cb_129",   ram[1][129],   8'h01);
      check_eq("o_cb_image", count_bad(1), 0);
      check_eq("o_wz_writes", wr_cnt[2], 16384);

      // Word 5 = 8001
      for (int w = 0; w < 1024; w++) rom[w] = 16'h0000;
      rom[5] = 16'h8001;
      fill_ram();
      run_load(0, 1'b0);
      check_eq("s_px80",      ram[0][80], 8'h01);
      check_eq("s_px95",      ram[0][95], 8'h01);
      check_eq("s_image",     count_bad(0), 0);
      check_eq("s_fg",        fg_count[0], 2);
      check_eq("s_addr_at95", addr_at95, 6);
      check_eq("s_rd_at95",   rd_at95, 1);
      check_eq("s_wz_writes", wr_cnt[2], 2);
      check_eq("s_wz_addr0",  wz_addr[0], 80);
      check_eq("s_wz_addr1",  wz_addr[1], 95);
      check_eq("s_wz_done",   done_n[2], 16385);
      check_eq("s_wz_image",  count_bad(2), 0);

      // Reset during word 300, then a full reload
      rom[300] = 16'hA5C3;
      fill_ram();
      run_load(4810, 1'b0);
      fill_ram();
      run_load(0, 1'b0);
      check_eq("r_done_cycle", done_n[0], 16385);
      check_eq("r_wr_count",   wr_cnt[0], 16384);
      check_eq("r_image",      count_bad(0), 0);
      check_eq("r_fg",         fg_count[0], 10);
      check_eq("r_cb_image",   count_bad(1), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/dt_sti_loader.md
Name: dt_sti_loader

Overview:
Upstream stage of the DT distance-transform core. Reads the packed 128x128 binary source image from sti_ROM (1024 x 16-bit words) and expands it into res_RAM as one byte per pixel (8'h00 background, 8'h01 object). Its output is the initial image that the DT forward pass operates on in place. It owns the sti_ROM port and the res_RAM write port only while loading; the top-level mux gives both ports to DT after load_done.

Parameters:
CLEAR_BORDER, 0, when 1 force row 0, row 127, col 0, col 127 pixels to 8'h00 regardless of source bit
WRITE_ZEROS, 1, when 0 suppress res_wr for pixels whose written value is 8'h00 (relies on a pre-cleared RAM); cycle timing is unchanged

Ports:
clk  in  1  system clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle load request, sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until load_done
load_done  out  1  one-cycle pulse after the last pixel write
fg_count  out  15  number of 8'h01 pixels written in the last load (0..16384)
sti_rd  out  1  ROM read enable
sti_addr  out  10  ROM word address
sti_di  in  16  ROM data, valid at the posedge after the sti_rd/sti_addr cycle (ROM updates on negedge)
res_wr  out  1  RAM write enable (RAM writes on posedge)
res_addr  out  14  RAM pixel address = row*128 + col
res_do  out  8  RAM write data

Behaviour:
- Reset: state IDLE; busy, load_done, sti_rd, res_wr = 0; sti_addr, res_addr, res_do = 0; fg_count = 0; word counter and bit counter = 0.
- Pixel mapping: word w, bit index b (15..0) -> res_addr = {w, 4'(15-b)}. sti_di[15] is the leftmost pixel of the word.
- FSM states are IDLE, FETCH, UNPACK, DONE.
- IDLE: on start=1, go to FETCH. Clear fg_count and the word counter. Set busy.
- FETCH (1 cycle): sti_rd=1, sti_addr=w. On the next posedge, latch sti_di into the 16-bit shift register, set k=0, go to UNPACK.
- UNPACK (16 cycles per word): res_wr=1 (subject to WRITE_ZEROS), res_addr={w,k}, res_do={7'b0,bit}.
  - bit = shreg[15], masked to 0 on border pixels when CLEAR_BORDER=1.
  - Each cycle, shift left and increment k. Increment fg_count when bit=1.
- Prefetch: in the k=15 cycle with w<1023, also drive sti_rd=1 and sti_addr=w+1. At the next posedge, load the shift register from sti_di, increment w, set k=0, and stay in UNPACK. There is no bubble between words.
- After the k=15 cycle of w=1023, go to DONE. In DONE: load_done=1 for one cycle, busy=0, then return to IDLE.
- Latency: if start is sampled at posedge P, FETCH occupies cycle P+1. Writes occupy the 16384 cycles P+2..P+16385. load_done is high in cycle P+16386.
- sti_rd=0 and res_wr=0 in all other cycles. sti_addr and res_addr hold their last values when idle.
- start while busy: ignored, with no restart.
- start coincident with the load_done cycle: ignored. It is accepted only in IDLE.
- reset mid-load: synchronous return to IDLE the same edge. Partial RAM contents are left as written, and fg_count is zeroed. The next start reloads the full image from word 0.
- fg_count holds its final value until the next accepted start or reset. It does not saturate or wrap: the maximum is 16384, which fits in 15 bits.

Decomposition:
- Shared package dt_pkg:
  - IMG_W=128, IMG_H=128, STI_WORDS=1024, PIX_BITS=8.
  - Localparams PIX_BG=8'h00, PIX_OBJ=8'h01.
  - Loader state enum {IDLE, FETCH, UNPACK, DONE}.
- No sub-module is required. The border-mask function (row/col from res_addr[13:7]/[6:0]) belongs in dt_pkg so DT can reuse it.

Test Plan:
- All-zero ROM, start -> 16384 writes of 8'h00, fg_count=0, load_done exactly 16386 cycles after start is sampled, no write gaps.
- All-ones ROM:
  - CLEAR_BORDER=0 -> every res_M=8'h01, fg_count=16384.
  - CLEAR_BORDER=1 -> fg_count=15876 (126*126); res_M[0], [127], [128], [16383] = 00; res_M[129]=01.
- ROM word 5 = 16'h8001, all others 0 -> res_M[80]=01, res_M[95]=01, all others 00, fg_count=2. Check that sti_addr=6 is presented during the write cycle of pixel 95.
- WRITE_ZEROS=0 with the 16'h8001 image -> exactly 2 res_wr pulses (addresses 80, 95); load_done timing is identical to WRITE_ZEROS=1.
- Reset asserted during word 300 -> next cycle: IDLE, busy=0, fg_count=0, no writes. A following start runs a full load from addr 0 and gives the correct final image.
- start pulsed again at cycle 500 and in the load_done cycle -> no restart, total writes still 16384, exactly one load_done pulse.
